// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel luma pipeline.
//   PIX_W         bits per luma pixel
//   PIX_PER_BEAT  pixels carried by one stream beat
//   BEAT_W        width of one stream beat
//   beat_t        one raw stream beat, byte i = pixel i
//   tagged_beat_t beat plus its end-of-frame tag, as stored in the sink FIFO
package sobel_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_BEAT = 16;
  localparam int BEAT_W       = PIX_W * PIX_PER_BEAT;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef struct packed {
    logic  last;
    beat_t data;
  } tagged_beat_t;

endpackage

// File: rtl/luma_stream_sink_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, rst  clock and synchronous active-high reset (pointers only)
//   wr_en     write request; ignored while full
//   wr_data   word to write
//   rd_en     pop request; ignored while empty
//   rd_data   head-of-FIFO word, combinational from the read pointer
//   full      occupancy == DEPTH (registered state only)
//   empty     occupancy == 0 (registered state only)
//   level     occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push;
  logic             pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = wr_ptr_reg - rd_ptr_reg;

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage is not reset; writes are simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Show-ahead: the head word is visible as soon as the write pointer moves.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/luma_stream_sink.sv
// luma_stream_sink: consumer end of the 128-bit luma beat stream.
// Buffers un-stallable input beats in a show-ahead FIFO, tags the last beat of
// each frame, counts beats lost to overflow and re-presents them on a
// valid/ready handshake.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   data_in     incoming beat, byte i = pixel i
//   valid_in    beat present this cycle (no backpressure)
//   m_data      head-of-FIFO beat
//   m_last      m_data is the final beat of a frame
//   m_valid     FIFO non-empty
//   m_ready     downstream accepts; pop on m_valid && m_ready
//   level       FIFO occupancy, 0..DEPTH
//   overflow    sticky drop flag
//   ovf_clr     clears overflow and drop_cnt
//   drop_cnt    saturating count of dropped beats
//   frame_done  one-cycle pulse after a beat with m_last is popped
module luma_stream_sink
  import sobel_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FRAME_BEATS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BEAT_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic [BEAT_W-1:0]        m_data,
  output logic                     m_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     frame_done
);

  localparam int IN_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  tagged_beat_t    wr_beat;
  tagged_beat_t    rd_beat;
  logic            full;
  logic            empty;
  logic            drop;
  logic            last_tag;
  logic [IN_W-1:0] in_cnt_reg;
  logic            overflow_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic            frame_done_reg;

  assign last_tag     = (in_cnt_reg == IN_W'(FRAME_BEATS - 1));
  assign wr_beat.last = last_tag;
  assign wr_beat.data = data_in;

  // Full is the registered state, so a pop in the same cycle does not save the beat.
  assign drop = valid_in && full;

  sync_fifo #(
    .WIDTH ($bits(tagged_beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (valid_in),
    .wr_data (wr_beat),
    .rd_en   (m_ready),
    .rd_data (rd_beat),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign m_valid = !empty;
  assign m_data  = rd_beat.data;
  assign m_last  = rd_beat.last;

  // Frame position follows every offered beat, dropped or not, so a drop
  // never shifts where later frame boundaries fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_reg <= '0;
    end else if (valid_in) begin
      in_cnt_reg <= last_tag ? '0 : in_cnt_reg + IN_W'(1);
    end
  end

  // A drop in the same cycle as a clear wins: the new drop is the first counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (ovf_clr)
        drop_cnt_reg <= CNT_W'(1);
      else if (drop_cnt_reg != '1)
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) frame_done_reg <= 1'b0;
    else     frame_done_reg <= m_valid && m_ready && m_last;
  end

  assign overflow   = overflow_reg;
  assign drop_cnt   = drop_cnt_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_luma_stream_sink.sv
module tb_luma_stream_sink;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] data_in;
  logic         valid_in;
  logic [127:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;
  logic [2:0]   level;
  logic         overflow;
  logic         ovf_clr;
  logic [15:0]  drop_cnt;
  logic         frame_done;

  // Second instance with a 2-bit drop counter for the saturation check.
  logic         s_valid_in;
  logic [127:0] s_m_data;
  logic         s_m_last;
  logic         s_m_valid;
  logic         s_m_ready;
  logic [2:0]   s_level;
  logic         s_overflow;
  logic         s_ovf_clr;
  logic [1:0]   s_drop_cnt;
  logic         s_frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  luma_stream_sink #(.DEPTH(4), .FRAME_BEATS(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
    .drop_cnt(drop_cnt), .frame_done(frame_done)
  );

  luma_stream_sink #(.DEPTH(4), .FRAME_BEATS(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(s_valid_in),
    .m_data(s_m_data), .m_last(s_m_last), .m_valid(s_m_valid), .m_ready(s_m_ready),
    .level(s_level), .overflow(s_overflow), .ovf_clr(s_ovf_clr),
    .drop_cnt(s_drop_cnt), .frame_done(s_frame_done)
  );

  function automatic logic [127:0] pat(input int i);
    logic [15:0] w;
    w = 16'hA500 + 16'(i);
    return {8{w}};
  endfunction

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int idx);
    valid_in = v;
    data_in  = pat(idx);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b1; data_in = pat(0); m_ready = 1'b0; ovf_clr = 1'b0;
    s_valid_in = 1'b0; s_m_ready = 1'b0; s_ovf_clr = 1'b0;

    // 1 Reset with valid_in held high: nothing is written.
    tick(); tick();
    chk("rst_m_valid", 128'(m_valid), 128'(0));
    chk("rst_level", 128'(level), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    chk("rst_frame_done", 128'(frame_done), 128'(0));
    rst = 1'b0; valid_in = 1'b0;
    tick();
    chk("rst_no_write", 128'(level), 128'(0));

    // 2 Passthrough A,B,C with m_ready=1.
    m_ready = 1'b1;
    drive(1, 1); tick();
    chk("pt_a_valid", 128'(m_valid), 128'(1));
    chk("pt_a_data", m_data, pat(1));
    chk("pt_a_last", 128'(m_last), 128'(0));
    drive(1, 2); tick();
    chk("pt_b_data", m_data, pat(2));
    chk("pt_b_last", 128'(m_last), 128'(0));
    chk("pt_b_level", 128'(level), 128'(1));
    drive(1, 3); tick();
    chk("pt_c_data", m_data, pat(3));
    chk("pt_c_last", 128'(m_last), 128'(1));
    chk("pt_c_fd_before", 128'(frame_done), 128'(0));
    drive(0, 0); tick();
    chk("pt_fd_pulse", 128'(frame_done), 128'(1));
    chk("pt_empty", 128'(m_valid), 128'(0));
    tick();
    chk("pt_fd_end", 128'(frame_done), 128'(0));

    // 3 Overflow: six beats with m_ready=0; beats 5 and 6 are dropped.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 10 + i); tick();
    end
    drive(0, 0);
    chk("ov_level", 128'(level), 128'(4));
    chk("ov_overflow", 128'(overflow), 128'(1));
    chk("ov_drop_cnt", 128'(drop_cnt), 128'(2));
    chk("ov_hold_data", m_data, pat(10));
    tick();
    chk("ov_hold_data2", m_data, pat(10));
    m_ready = 1'b1;
    chk("ov_h1_data", m_data, pat(10));
    chk("ov_h1_last", 128'(m_last), 128'(0));
    tick();
    chk("ov_h2_data", m_data, pat(11));
    chk("ov_h2_last", 128'(m_last), 128'(0));
    tick();
    chk("ov_h3_data", m_data, pat(12));
    chk("ov_h3_last", 128'(m_last), 128'(1));
    tick();
    chk("ov_h4_data", m_data, pat(13));
    chk("ov_h4_last", 128'(m_last), 128'(0));
    chk("ov_fd", 128'(frame_done), 128'(1));
    tick();
    chk("ov_drained", 128'(level), 128'(0));
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ov_clr_flag", 128'(overflow), 128'(0));
    chk("ov_clr_cnt", 128'(drop_cnt), 128'(0));

    // 4 Full plus pop in the same cycle: the new beat is still dropped.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 20 + i); tick();
    end
    chk("fp_full", 128'(level), 128'(4));
    drive(1, 24); m_ready = 1'b1; tick();
    drive(0, 0); m_ready = 1'b0;
    chk("fp_level", 128'(level), 128'(3));
    chk("fp_drop_cnt", 128'(drop_cnt), 128'(1));
    chk("fp_overflow", 128'(overflow), 128'(1));
    chk("fp_head", m_data, pat(21));

    // Reset mid-operation discards buffered beats and restarts frame position.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_level", 128'(level), 128'(0));
    chk("mid_rst_valid", 128'(m_valid), 128'(0));
    chk("mid_rst_ovf", 128'(overflow), 128'(0));

    // 5 Frame alignment survives a dropped beat (global index 4 dropped).
    for (int i = 0; i < 4; i++) begin
      drive(1, 30 + i); tick();
    end
    drive(1, 34); tick();
    chk("fa_drop_cnt", 128'(drop_cnt), 128'(1));
    chk("fa_level", 128'(level), 128'(4));
    drive(0, 0); m_ready = 1'b1; tick();
    chk("fa_head1", m_data, pat(31));
    drive(1, 35); tick();
    chk("fa_level_push_pop", 128'(level), 128'(3));
    chk("fa_head2", m_data, pat(32));
    chk("fa_last2", 128'(m_last), 128'(1));
    drive(0, 0); tick();
    chk("fa_head3", m_data, pat(33));
    chk("fa_last3", 128'(m_last), 128'(0));
    chk("fa_fd0", 128'(frame_done), 128'(1));
    tick();
    chk("fa_head5", m_data, pat(35));
    chk("fa_last5", 128'(m_last), 128'(1));
    tick();
    chk("fa_empty", 128'(m_valid), 128'(0));
    chk("fa_fd1", 128'(frame_done), 128'(1));
    drive(1, 36); tick();
    chk("fa_last6", 128'(m_last), 128'(0));
    drive(1, 37); tick();
    chk("fa_last7", 128'(m_last), 128'(0));
    drive(1, 38); tick();
    chk("fa_data8", m_data, pat(38));
    chk("fa_last8", 128'(m_last), 128'(1));
    drive(0, 0); tick();
    chk("fa_fd2", 128'(frame_done), 128'(1));

    // 6 Clear with a simultaneous drop: the drop wins.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 40 + i); tick();
    end
    chk("clr_pre_cnt", 128'(drop_cnt), 128'(2));
    drive(1, 45); ovf_clr = 1'b1; tick();
    chk("clr_drop_ovf", 128'(overflow), 128'(1));
    chk("clr_drop_cnt", 128'(drop_cnt), 128'(1));
    drive(0, 0); tick();
    ovf_clr = 1'b0;
    chk("clr_only_ovf", 128'(overflow), 128'(0));
    chk("clr_only_cnt", 128'(drop_cnt), 128'(0));
    chk("clr_keeps_fifo", 128'(level), 128'(4));

    // Saturation: CNT_W=2, four pushes then five drops.
    s_valid_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("sat_cnt_2", 128'(s_drop_cnt), 128'(2));
    for (int i = 0; i < 3; i++) tick();
    s_valid_in = 1'b0;
    chk("sat_cnt_3", 128'(s_drop_cnt), 128'(3));
    chk("sat_ovf", 128'(s_overflow), 128'(1));
    chk("sat_level", 128'(s_level), 128'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
